// File: rtl/dac_serializer.sv
// Stereo DAC serializer: bit-clock master with a double-buffered sample path.
// Shifts 16-bit left/right samples MSB first onto the codec DAC data line.
//
// Ports:
//   clk          system clock
//   reset_n      synchronous active-low reset
//   leftIn       left sample, captured on accept
//   rightIn      right sample, captured on accept
//   sampleValid  leftIn/rightIn valid
//   sampleReady  holding buffer empty, a sample can be accepted
//   BCLK         bit clock, clk / (2*BCLK_DIV)
//   LRCK         channel select, 1 = left, 0 = right
//   WCLK         high while data bits are on serialOut
//   serialOut    serial data, MSB first
//   underrun     one-clk pulse: frame began with no new sample

module dac_serializer #(
    parameter int DATA_W     = 16,
    parameter int BCLK_DIV   = 1,
    parameter int HALF_BCLKS = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] leftIn,
    input  logic [DATA_W-1:0] rightIn,
    input  logic              sampleValid,
    output logic              sampleReady,
    output logic              BCLK,
    output logic              LRCK,
    output logic              WCLK,
    output logic              serialOut,
    output logic              underrun
);

    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int CNT_W = $clog2(HALF_BCLKS);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(HALF_BCLKS - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] FIRST_BIT = CNT_W'(1);

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

    buf_state_t buf_q;
    buf_state_t buf_d;

    logic [DIV_W-1:0]  div_q;
    logic              bclk_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              lrck_q;
    logic              lrck_nxt;
    logic              wclk_q;
    logic              sout_q;
    logic              urun_q;
    logic              urun_d;
    logic [DATA_W-1:0] hold_l;
    logic [DATA_W-1:0] hold_r;
    logic [DATA_W-1:0] act_l;
    logic [DATA_W-1:0] act_r;
    logic [DATA_W-1:0] sh_q;
    logic [DATA_W-1:0] word;

    logic tick;
    logic fe;
    logic wrap;
    logic boundary;
    logic in_data;
    logic first_bit;
    logic capture;
    logic load_act;

    // Slot decode looks at the count that is about to be registered, so
    // WCLK/serialOut line up with the bit_cnt value they are shown with.
    assign tick      = (div_q == DIV_LAST);
    assign fe        = tick & bclk_q;
    assign wrap      = (cnt_q == CNT_LAST);
    assign cnt_nxt   = wrap ? '0 : cnt_q + FIRST_BIT;
    assign lrck_nxt  = wrap ? ~lrck_q : lrck_q;
    assign boundary  = fe & wrap & ~lrck_q;
    assign in_data   = (cnt_nxt != '0) && (cnt_nxt <= DATA_LAST);
    assign first_bit = (cnt_nxt == FIRST_BIT);
    assign word      = lrck_nxt ? act_l : act_r;

    // Divider and bit clock
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_q  <= '0;
            bclk_q <= 1'b0;
        end else if (tick) begin
            div_q  <= '0;
            bclk_q <= ~bclk_q;
        end else begin
            div_q  <= div_q + DIV_ONE;
        end
    end

    // Slot counter, channel select and serial data, all on BCLK falls
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            lrck_q <= 1'b1;
            wclk_q <= 1'b0;
            sout_q <= 1'b0;
            sh_q   <= '0;
        end else if (fe) begin
            cnt_q  <= cnt_nxt;
            lrck_q <= lrck_nxt;
            wclk_q <= in_data;
            unique case (1'b1)
                !in_data: begin
                    sout_q <= 1'b0;
                end
                first_bit: begin
                    sout_q <= word[DATA_W-1];
                    sh_q   <= {word[DATA_W-2:0], 1'b0};
                end
                default: begin
                    sout_q <= sh_q[DATA_W-1];
                    sh_q   <= {sh_q[DATA_W-2:0], 1'b0};
                end
            endcase
        end
    end

    // Holding-buffer state: the frame boundary is resolved before a
    // same-edge accept, so an empty buffer at the boundary repeats the
    // active sample even if new data arrives on that very clk.
    always_comb begin
        buf_d       = buf_q;
        capture     = 1'b0;
        load_act    = 1'b0;
        urun_d      = 1'b0;
        sampleReady = 1'b0;
        unique case (buf_q)
            BUF_EMPTY: begin
                sampleReady = 1'b1;
                if (boundary) begin
                    urun_d = 1'b1;
                end
                if (sampleValid) begin
                    capture = 1'b1;
                    buf_d   = BUF_FULL;
                end
            end
            BUF_FULL: begin
                if (boundary) begin
                    load_act = 1'b1;
                    buf_d    = BUF_EMPTY;
                end
            end
            default: begin
                buf_d = BUF_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            buf_q  <= BUF_EMPTY;
            urun_q <= 1'b0;
            hold_l <= '0;
            hold_r <= '0;
            act_l  <= '0;
            act_r  <= '0;
        end else begin
            buf_q  <= buf_d;
            urun_q <= urun_d;
            if (capture) begin
                hold_l <= leftIn;
                hold_r <= rightIn;
            end
            if (load_act) begin
                act_l <= hold_l;
                act_r <= hold_r;
            end
        end
    end

    assign BCLK      = bclk_q;
    assign LRCK      = lrck_q;
    assign WCLK      = wclk_q;
    assign serialOut = sout_q;
    assign underrun  = urun_q;

endmodule

// File: tb/tb_dac_serializer.sv
// Bench for dac_serializer: frame-position model plus decoded-frame checks.
// Stimulus queue drives the valid/ready handshake with random sample data.

module tb_dac_serializer;

    localparam int DW  = 16;
    localparam int DIV = 1;
    localparam int H   = 32;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [DW-1:0] leftIn = '0;
    logic [DW-1:0] rightIn = '0;
    logic          sampleValid = 1'b0;
    logic          sampleReady;
    logic          BCLK;
    logic          LRCK;
    logic          WCLK;
    logic          serialOut;
    logic          underrun;

    always #5 clk = ~clk;

    dac_serializer #(
        .DATA_W    (DW),
        .BCLK_DIV  (DIV),
        .HALF_BCLKS(H)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .leftIn     (leftIn),
        .rightIn    (rightIn),
        .sampleValid(sampleValid),
        .sampleReady(sampleReady),
        .BCLK       (BCLK),
        .LRCK       (LRCK),
        .WCLK       (WCLK),
        .serialOut  (serialOut),
        .underrun   (underrun)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    // Reference model: outputs follow from edges since reset release
    int            t = 0;
    logic [DW-1:0] mL = '0;
    logic [DW-1:0] mR = '0;
    logic [31:0]   hq[$];
    logic          eU = 1'b0;

    task automatic model_step();
        logic rdy_pre;
        logic bnd;
        if (!reset_n) begin
            t = 0;
            mL = '0;
            mR = '0;
            hq.delete();
            eU = 1'b0;
        end else begin
            rdy_pre = (hq.size() == 0);
            t++;
            bnd = (t % (2*DIV) == 0) && ((t / (2*DIV)) % (2*H) == 0);
            eU = 1'b0;
            if (bnd) begin
                if (hq.size() != 0) {mL, mR} = hq.pop_front();
                else eU = 1'b1;
            end
            if (sampleValid && rdy_pre) hq.push_back({leftIn, rightIn});
        end
    endtask

    task automatic check_outputs();
        int nfe;
        int s;
        int k;
        logic eL;
        logic eW;
        logic eS;
        logic [DW-1:0] w;
        nfe = t / (2*DIV);
        s   = nfe % (2*H);
        k   = s % H;
        eL  = (s < H);
        eW  = (k >= 1) && (k <= DW);
        w   = eL ? mL : mR;
        eS  = eW ? w[DW-k] : 1'b0;
        chk("BCLK", BCLK, (t / DIV) % 2);
        chk("LRCK", LRCK, eL);
        chk("WCLK", WCLK, eW);
        chk("serialOut", serialOut, eS);
        chk("underrun", underrun, eU);
        chk("sampleReady", sampleReady, hq.size() == 0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            check_outputs();
        end
    end

    // Handshake driver: hold each queued sample until it is accepted
    logic [31:0] tx_q[$];

    initial begin
        logic acc;
        forever begin
            @(posedge clk);
            acc = reset_n && sampleValid && sampleReady;
            @(negedge clk);
            #1;
            if (acc) void'(tx_q.pop_front());
            if (tx_q.size() != 0) begin
                sampleValid = 1'b1;
                {leftIn, rightIn} = tx_q[0];
            end else begin
                sampleValid = 1'b0;
            end
        end
    end

    task automatic wait_rise(output logic u);
        logic prev;
        logic ok;
        int n;
        prev = LRCK;
        ok = 1'b0;
        n = 0;
        while (n < 400 && !ok) begin
            @(negedge clk);
            n++;
            if (LRCK && !prev) ok = 1'b1;
            prev = LRCK;
        end
        chk("frame_start_seen", ok, 1);
        u = underrun;
    endtask

    task automatic grab(output logic [DW-1:0] l, output logic [DW-1:0] r);
        l = '0;
        r = '0;
        repeat (127) begin
            @(negedge clk);
            if (!BCLK && WCLK) begin
                if (LRCK) l = {l[DW-2:0], serialOut};
                else      r = {r[DW-2:0], serialOut};
            end
        end
    endtask

    task automatic frame(input string nm, input logic [DW-1:0] el,
                         input logic [DW-1:0] er, input logic eu);
        logic u;
        logic [DW-1:0] l;
        logic [DW-1:0] r;
        wait_rise(u);
        chk({nm, "_underrun"}, u, eu);
        grab(l, r);
        chk({nm, "_left"}, l, el);
        chk({nm, "_right"}, r, er);
    endtask

    initial begin
        int n;
        logic u;
        logic [DW-1:0] l;
        logic [DW-1:0] r;
        logic [31:0] smp[4];

        reset_n = 1'b0;
        repeat (10) @(negedge clk);

        tx_q.push_back({16'h0009, 16'h0006});
        reset_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (LRCK && n < 200);
        chk("lrck_first_fall", n, 64);

        frame("f1_basic", 16'h0009, 16'h0006, 1'b0);
        frame("f2_repeat", 16'h0009, 16'h0006, 1'b1);

        tx_q.push_back({16'h8000, 16'hFFFF});
        frame("f3_repeat", 16'h0009, 16'h0006, 1'b1);
        frame("f4_extreme", 16'h8000, 16'hFFFF, 1'b0);

        for (int i = 0; i < 4; i++) begin
            smp[i] = $urandom();
            tx_q.push_back(smp[i]);
        end
        frame("f5_repeat", 16'h8000, 16'hFFFF, 1'b1);
        for (int i = 0; i < 4; i++) begin
            frame("b2b", smp[i][31:16], smp[i][15:0], 1'b0);
        end

        wait_rise(u);
        chk("f10_underrun", u, 1);
        repeat (16) @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        grab(l, r);
        chk("rst_f0_left", l, 16'h0000);
        chk("rst_f0_right", r, 16'h0000);
        frame("rst_f1", 16'h0000, 16'h0000, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dac_serializer.md
Name: dac_serializer

Overview:
- Transmit-side counterpart to the ADC serial receiver; serializes 16-bit signed left/right samples onto the codec DAC data line.
- Bit-clock master: generates BCLK, LRCK and the WCLK word-valid strobe from clk.
- Double-buffered: the processing chain hands over one stereo sample per frame via a valid/ready handshake, and frame-boundary transfer keeps the outputs glitch-free.

Parameters:
DATA_W, 16, sample width in bits (leftIn/rightIn, shift registers)
BCLK_DIV, 1, clk cycles per BCLK half-period (BCLK = clk / (2*BCLK_DIV))
HALF_BCLKS, 32, BCLK periods per channel half-frame; must be >= DATA_W+1

Ports:
clk  input  1  system clock
reset_n  input  1  synchronous active-low reset
leftIn  input  DATA_W  signed left sample
rightIn  input  DATA_W  signed right sample
sampleValid  input  1  leftIn/rightIn valid
sampleReady  output  1  holding buffer empty, can accept
BCLK  output  1  bit clock
LRCK  output  1  channel select; 1 = left, 0 = right
WCLK  output  1  high while data bits are on serialOut
serialOut  output  1  serial data, MSB first
underrun  output  1  one-clk pulse: frame started with no new sample

Behaviour:
- Reset (reset_n low at posedge clk) applies on the next edge, including mid-frame:
  - BCLK=0, LRCK=1, WCLK=0, serialOut=0, underrun=0, sampleReady=1.
  - Divider, bit counter, holding and active registers all cleared to 0.
- Divider: counter 0..BCLK_DIV-1; at terminal count it wraps and BCLK toggles. The first BCLK rise is BCLK_DIV clks after reset release.
- Falling edge (fe): the clk edge on which BCLK goes 1->0. All of the following update only on fe, registered at that same clk edge:
  - bit_cnt, LRCK, WCLK, serialOut.
- bit_cnt:
  - Range 0..HALF_BCLKS-1; increments on each fe.
  - On wrap to 0, LRCK toggles.
  - Reset state is bit_cnt=0, LRCK=1, i.e. slot 0 of the left half.
- Slot mapping within each half-frame:
  - bit_cnt=0: WCLK=0, serialOut=0 (one-BCLK delay after LRCK edge).
  - bit_cnt=k, k=1..DATA_W: WCLK=1, serialOut = active channel bit [DATA_W-k]. The channel is left when LRCK=1, right when LRCK=0.
  - bit_cnt > DATA_W: WCLK=0, serialOut=0.
- Frame boundary: the fe on which LRCK goes 0->1 (right half wraps into left).
  - Holding full: copy to active left/right, mark holding empty; sampleReady=1 on the next clk.
  - Holding empty: active registers keep their previous values (last sample repeats); underrun=1 for exactly that one clk.
  - The first frame after reset transmits the cleared active value (all zeros) and does not flag underrun.
- Handshake:
  - Accept = sampleValid & sampleReady at posedge clk. leftIn/rightIn are captured into holding, and sampleReady=0 from the next clk.
  - At most one sample is buffered; while sampleReady=0, sampleValid is ignored.
- Simultaneous accept and boundary with holding empty:
  - The boundary is evaluated first, so the active registers repeat and underrun pulses.
  - The new sample is captured into holding and sent in the following frame.
- Data is transmitted bit-exact; no arithmetic, rounding or sign manipulation.
- Latency: a sample accepted before boundary N appears on serialOut starting at bit_cnt=1 of frame N's left half.

Test Plan:
(All scenarios: BCLK_DIV=1, HALF_BCLKS=32, so frame = 64 BCLK = 128 clk.)
1. Reset: hold reset_n=0 for 10 clk -> BCLK=0, LRCK=1, WCLK=0, serialOut=0, sampleReady=1, underrun=0 throughout. After release, BCLK toggles every clk and the first LRCK 1->0 occurs 64 clk after release.
2. Basic frame: accept leftIn=16'h0009, rightIn=16'h0006 during frame 0 -> frame 0 serialOut all 0. In frame 1:
   - LRCK=1 slots 1..16 carry 0000000000001001 with WCLK=1.
   - LRCK=0 slots 1..16 carry 0000000000000110.
   - WCLK=0 and serialOut=0 in slots 0 and 17..31.
3. Extremes: leftIn=16'h8000, rightIn=16'hFFFF -> left slot 1 = 1 then 15 zeros; right slots 1..16 all 1. serialOut=0 at right slot 17.
4. Underrun: after scenario 2, send no further samples -> every later frame repeats 0009/0006, underrun is a 1-clk pulse at each boundary, and sampleReady stays 1.
5. Back-to-back: sampleValid held high with incrementing data ->
   - sampleReady drops 1 clk after each accept and rises 1 clk after each boundary.
   - Exactly one sample is consumed per frame, in order, with no underrun.
6. Mid-frame reset: pull reset_n low at left slot 8 of a data frame -> the next clk shows all reset values. After release, the first frame is all-zero data from cleared registers.
